dec_entry_to_bin: RTL and testbench

//  Operand entry path for the ALU: accepts decimal digits one per strobe
//  (most significant digit first) and accumulates them into an unsigned binary

---
 rtl/dec_entry_to_bin_if.sv | 32 +++
 rtl/dec_entry_to_bin.sv | 104 ++++++++++
 tb/tb_dec_entry_to_bin.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dec_entry_to_bin_if.sv
`default_nettype none
// ============================================================================
// Module   : dec_entry_to_bin_if
// Brief    : Digit-entry strobes and operand/result bus for dec_entry_to_bin
// Revision : 1.0
// ============================================================================
interface dec_entry_to_bin_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 2
);
  logic             digit_valid;
  logic [3:0]       digit;
  logic             enter;
  logic             clear;
  logic [WIDTH-1:0] partial;
  logic [CNT_W-1:0] digit_count;
  logic [WIDTH-1:0] num;
  logic             num_valid;
  logic             error;
  logic             overflow;

  modport master (
    output digit_valid, digit, enter, clear,
    input  partial, digit_count, num, num_valid, error, overflow
  );

  modport slave (
    input  digit_valid, digit, enter, clear,
    output partial, digit_count, num, num_valid, error, overflow
  );
endinterface
`default_nettype wire

// File: rtl/dec_entry_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : dec_entry_to_bin
// Brief    : Accumulates MSD-first decimal digits into an unsigned operand
// Revision : 1.0
// ============================================================================
module dec_entry_to_bin #(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3,
  parameter int CNT_W      = 2
) (
  input  wire                 clk,
  input  wire                 rst,
  dec_entry_to_bin_if.slave   bus
);
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ENTRY = 2'd1;
  localparam logic [1:0] c_ERR   = 2'd2;

  localparam logic [WIDTH+3:0] c_MAX_VAL   = {4'b0000, {WIDTH{1'b1}}};
  localparam logic [CNT_W-1:0] c_MAX_COUNT = CNT_W'(MAX_DIGITS);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_partial;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_num;
  logic             r_num_valid;
  logic             r_error;
  logic             r_overflow;

  logic [WIDTH+3:0] w_ext;
  logic [WIDTH+3:0] w_next;
  logic             w_illegal;
  logic             w_fits;

  // partial is zero in IDLE, so the same multiply-add yields the first digit too
  assign w_ext     = {4'b0000, r_partial};
  assign w_next    = (w_ext << 3) + (w_ext << 1) + {{WIDTH{1'b0}}, bus.digit};
  assign w_illegal = (bus.digit > 4'd9);
  assign w_fits    = (w_next <= c_MAX_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_partial   <= '0;
      r_count     <= '0;
      r_num       <= '0;
      r_num_valid <= 1'b0;
      r_error     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_num_valid <= 1'b0;
      if (bus.clear) begin
        r_state    <= c_IDLE;
        r_partial  <= '0;
        r_count    <= '0;
        r_error    <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        case (r_state)
          c_IDLE, c_ENTRY: begin
            if (bus.enter) begin
              if (r_state == c_ENTRY) begin
                r_num       <= r_partial;
                r_num_valid <= 1'b1;
                r_partial   <= '0;
                r_count     <= '0;
                r_state     <= c_IDLE;
              end
            end else if (bus.digit_valid) begin
              if (w_illegal) begin
                r_state    <= c_ERR;
                r_error    <= 1'b1;
                r_overflow <= 1'b0;
              end else if (r_count != c_MAX_COUNT) begin
                if (w_fits) begin
                  r_partial <= w_next[WIDTH-1:0];
                  r_count   <= r_count + CNT_W'(1);
                  r_state   <= c_ENTRY;
                end else begin
                  r_state    <= c_ERR;
                  r_error    <= 1'b1;
                  r_overflow <= 1'b1;
                end
              end
            end
          end
          default: begin
            // ERR holds everything until clear
            r_state <= c_ERR;
          end
        endcase
      end
    end
  end

  assign bus.partial     = r_partial;
  assign bus.digit_count = r_count;
  assign bus.num         = r_num;
  assign bus.num_valid   = r_num_valid;
  assign bus.error       = r_error;
  assign bus.overflow    = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_dec_entry_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_entry_to_bin
// Brief    : Directed self-checking bench for dec_entry_to_bin
// Revision : 1.0
// ============================================================================
module tb_dec_entry_to_bin;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  dec_entry_to_bin_if #(.WIDTH(8), .CNT_W(2)) bus ();

  dec_entry_to_bin #(.WIDTH(8), .MAX_DIGITS(3), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one cycle of strobes, then sample 1 time unit after the edge
  task automatic apply(input logic dv, input logic [3:0] d, input logic en, input logic clr);
    @(negedge clk);
    bus.digit_valid = dv;
    bus.digit       = d;
    bus.enter       = en;
    bus.clear       = clr;
    @(posedge clk);
    #1;
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    bus.enter       = 1'b0;
    bus.clear       = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({bus.partial, bus.digit_count, bus.num, bus.num_valid, bus.error, bus.overflow} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got partial=%0d cnt=%0d num=%0d nv=%0b err=%0b ovf=%0b, want all 0",
               bus.partial, bus.digit_count, bus.num, bus.num_valid, bus.error, bus.overflow);
    end
  endtask

  task automatic test_basic();
    logic [3:0] digs [3] = '{4'd2, 4'd5, 4'd5};
    logic [7:0] exp_p [3] = '{8'd2, 8'd25, 8'd255};
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, digs[i], 1'b0, 1'b0);
      tests_run++;
      if (bus.partial !== exp_p[i] || bus.digit_count !== 2'(i + 1)) begin
        tests_failed++;
        $display("FAIL basic_partial[%0d]: got %0d cnt=%0d, want %0d cnt=%0d",
                 i, bus.partial, bus.digit_count, exp_p[i], i + 1);
      end
    end
    apply(1'b0, 4'd0, 1'b1, 1'b0);
    tests_run++;
    if (bus.num !== 8'd255 || bus.num_valid !== 1'b1 || bus.partial !== 8'd0 || bus.digit_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL basic_enter: got num=%0d nv=%0b p=%0d cnt=%0d, want 255 1 0 0",
               bus.num, bus.num_valid, bus.partial, bus.digit_count);
    end
    apply(1'b0, 4'd0, 1'b0, 1'b0);
    tests_run++;
    if (bus.num_valid !== 1'b0 || bus.num !== 8'd255) begin
      tests_failed++;
      $display("FAIL basic_pulse_width: got nv=%0b num=%0d, want 0 255", bus.num_valid, bus.num);
    end
  endtask

  task automatic test_overflow();
    apply(1'b1, 4'd2, 1'b0, 1'b0);
    apply(1'b1, 4'd5, 1'b0, 1'b0);
    apply(1'b1, 4'd6, 1'b0, 1'b0);
    tests_run++;
    if (bus.error !== 1'b1 || bus.overflow !== 1'b1 || bus.partial !== 8'd25 || bus.digit_count !== 2'd2) begin
      tests_failed++;
      $display("FAIL ovf_detect: got err=%0b ovf=%0b p=%0d cnt=%0d, want 1 1 25 2",
               bus.error, bus.overflow, bus.partial, bus.digit_count);
    end
    apply(1'b0, 4'd0, 1'b1, 1'b0);
    tests_run++;
    if (bus.num_valid !== 1'b0 || bus.num !== 8'd255 || bus.error !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_enter_ignored: got nv=%0b num=%0d err=%0b, want 0 255 1",
               bus.num_valid, bus.num, bus.error);
    end
    apply(1'b0, 4'd0, 1'b0, 1'b1);
    tests_run++;
    if (bus.error !== 1'b0 || bus.overflow !== 1'b0 || bus.partial !== 8'd0 || bus.num !== 8'd255) begin
      tests_failed++;
      $display("FAIL ovf_clear: got err=%0b ovf=%0b p=%0d num=%0d, want 0 0 0 255",
               bus.error, bus.overflow, bus.partial, bus.num);
    end
  endtask

  task automatic test_illegal_digit();
    apply(1'b1, 4'hA, 1'b0, 1'b0);
    tests_run++;
    if (bus.error !== 1'b1 || bus.overflow !== 1'b0 || bus.partial !== 8'd0) begin
      tests_failed++;
      $display("FAIL illegal_detect: got err=%0b ovf=%0b p=%0d, want 1 0 0",
               bus.error, bus.overflow, bus.partial);
    end
    apply(1'b1, 4'd3, 1'b0, 1'b0);
    tests_run++;
    if (bus.partial !== 8'd0 || bus.error !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_digit_ignored: got p=%0d err=%0b, want 0 1", bus.partial, bus.error);
    end
    apply(1'b0, 4'd0, 1'b0, 1'b1);
    apply(1'b1, 4'd3, 1'b0, 1'b0);
    tests_run++;
    if (bus.partial !== 8'd3 || bus.digit_count !== 2'd1 || bus.error !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_recover: got p=%0d cnt=%0d err=%0b, want 3 1 0",
               bus.partial, bus.digit_count, bus.error);
    end
    apply(1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_max_digits();
    apply(1'b1, 4'd1, 1'b0, 1'b0);
    apply(1'b1, 4'd2, 1'b0, 1'b0);
    apply(1'b1, 4'd3, 1'b0, 1'b0);
    apply(1'b1, 4'd4, 1'b0, 1'b0);
    tests_run++;
    if (bus.partial !== 8'd123 || bus.digit_count !== 2'd3 || bus.error !== 1'b0) begin
      tests_failed++;
      $display("FAIL max_digits_hold: got p=%0d cnt=%0d err=%0b, want 123 3 0",
               bus.partial, bus.digit_count, bus.error);
    end
    apply(1'b0, 4'd0, 1'b1, 1'b0);
    tests_run++;
    if (bus.num !== 8'd123 || bus.num_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL max_digits_enter: got num=%0d nv=%0b, want 123 1", bus.num, bus.num_valid);
    end
  endtask

  task automatic test_same_cycle();
    apply(1'b1, 4'd4, 1'b0, 1'b0);
    apply(1'b1, 4'd7, 1'b1, 1'b0);
    tests_run++;
    if (bus.num !== 8'd4 || bus.num_valid !== 1'b1 || bus.partial !== 8'd0 || bus.digit_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL enter_over_digit: got num=%0d nv=%0b p=%0d cnt=%0d, want 4 1 0 0",
               bus.num, bus.num_valid, bus.partial, bus.digit_count);
    end
    apply(1'b1, 4'd5, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b1);
    tests_run++;
    if (bus.num_valid !== 1'b0 || bus.num !== 8'd4 || bus.partial !== 8'd0) begin
      tests_failed++;
      $display("FAIL clear_over_enter: got nv=%0b num=%0d p=%0d, want 0 4 0",
               bus.num_valid, bus.num, bus.partial);
    end
  endtask

  task automatic test_leading_zeros();
    apply(1'b1, 4'd0, 1'b0, 1'b0);
    apply(1'b1, 4'd0, 1'b0, 1'b0);
    apply(1'b1, 4'd7, 1'b0, 1'b0);
    tests_run++;
    if (bus.partial !== 8'd7 || bus.digit_count !== 2'd3) begin
      tests_failed++;
      $display("FAIL leading_zeros: got p=%0d cnt=%0d, want 7 3", bus.partial, bus.digit_count);
    end
    apply(1'b0, 4'd0, 1'b1, 1'b0);
    tests_run++;
    if (bus.num !== 8'd7 || bus.num_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL leading_zeros_enter: got num=%0d nv=%0b, want 7 1", bus.num, bus.num_valid);
    end
  endtask

  task automatic test_async_reset();
    apply(1'b1, 4'd9, 1'b0, 1'b0);
    apply(1'b1, 4'd9, 1'b0, 1'b0);
    tests_run++;
    if (bus.partial !== 8'd99) begin
      tests_failed++;
      $display("FAIL async_pre: got p=%0d, want 99", bus.partial);
    end
    // Assert reset well away from any clock edge and look before the next one
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.partial, bus.digit_count, bus.num, bus.num_valid, bus.error, bus.overflow} !== 21'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got p=%0d cnt=%0d num=%0d nv=%0b err=%0b ovf=%0b, want all 0",
               bus.partial, bus.digit_count, bus.num, bus.num_valid, bus.error, bus.overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0, 4'd0, 1'b1, 1'b0);
    tests_run++;
    if (bus.num_valid !== 1'b0 || bus.num !== 8'd0) begin
      tests_failed++;
      $display("FAIL async_enter_idle: got nv=%0b num=%0d, want 0 0", bus.num_valid, bus.num);
    end
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    rst             = 1'b1;
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    bus.enter       = 1'b0;
    bus.clear       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_overflow();
    test_illegal_digit();
    test_max_digits();
    test_same_cycle();
    test_leading_zeros();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
`default_nettype wire
